// File: rtl/mxu_output_deskew.sv
// mxu_output_deskew: realigns skewed MXU result lanes into packed rows and buffers them in a small FWFT FIFO.
//   clk, rst            clock, async active-high reset
//   in_valid, in_data   skewed per-lane results; lane i arrives i cycles after lane 0
//   out_valid/ready     FIFO head handshake; out_data is the aligned packed row
//   count               rows stored
//   overflow, misalign  sticky error flags: full row dropped / partial aligned valids
module mxu_output_deskew #(
  parameter int LANES     = 4,
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LANES-1:0]               in_valid,
  input  logic [LANES*DATA_SIZE-1:0]     in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*DATA_SIZE-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  output logic                           misalign
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [LANES-1:0]           al_v;
  logic [LANES*DATA_SIZE-1:0] al_d;
  logic [LANES*DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic                       row, part, full, pop, push;
  // Lane i is delayed LANES-1-i cycles so every lane of a row lines up with the last lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int S = LANES - 1 - i;
    if (S == 0) begin : g_pass
      assign al_v[i] = in_valid[i];
      assign al_d[i*DATA_SIZE +: DATA_SIZE] = in_data[i*DATA_SIZE +: DATA_SIZE];
    end else begin : g_dly
      logic [S-1:0]         v;
      logic [DATA_SIZE-1:0] d [S];
      always_ff @(posedge clk or posedge rst)
        if (rst) v <= '0;
        else     v <= S'({v, in_valid[i]});
      always_ff @(posedge clk) begin
        d[0] <= in_data[i*DATA_SIZE +: DATA_SIZE];
        for (int k = 1; k < S; k++) d[k] <= d[k-1];
      end
      assign al_v[i] = v[S-1];
      assign al_d[i*DATA_SIZE +: DATA_SIZE] = d[S-1];
    end
  end
  assign row       = &al_v;
  assign part      = |al_v & ~row;
  assign out_valid = count != '0;
  assign full      = count == CW'(DEPTH);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign push      = row & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= al_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      misalign <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (row & full & ~pop) overflow <= 1'b1;
      if (part) misalign <= 1'b1;
    end
endmodule

// File: tb/tb_mxu_output_deskew.sv
// tb_mxu_output_deskew: scoreboard and vector-table bench for mxu_output_deskew (LANES=4, DEPTH=4).
module tb_mxu_output_deskew;
  logic        clk = 0, rst = 0, out_ready = 0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic        out_valid, overflow, misalign;
  logic [31:0] out_data;
  logic [2:0]  count;
  mxu_output_deskew #(.LANES(4), .DATA_SIZE(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow), .misalign(misalign));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { int start; logic [31:0] d; logic [3:0] m; } row_t;
  typedef struct { int nrows; int drop_row; int rdy_off; bit exp_ovf; bit exp_mis; int exp_out; } vec_t;
  row_t        sq[$];
  logic [31:0] mq[$];
  bit          m_ovf, m_mis;
  int          checks = 0, errors = 0, npop = 0, r_base = 0, r_off = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  task automatic add_row(int start, logic [31:0] d, logic [3:0] m);
    row_t r;
    r.start = start; r.d = d; r.m = m;
    sq.push_back(r);
  endtask
  task automatic step();
    logic [3:0]  am;
    logic [31:0] ad;
    bit          pop, push;
    @(posedge clk); #1;
    out_ready = (r_off < 0) ? ((cyc >= r_base + 20) ? 1'b1 : 1'($urandom_range(1))) : (cyc >= r_base + r_off);
    in_valid = '0;
    in_data  = '0;
    foreach (sq[k])
      for (int i = 0; i < 4; i++)
        if (sq[k].start + i == cyc && sq[k].m[i]) begin
          in_valid[i] = 1'b1;
          in_data[i*8 +: 8] = sq[k].d[i*8 +: 8];
        end
    @(negedge clk);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("out_data", out_data, mq.size() != 0 ? mq[0] : 32'h0);
    chk("overflow", overflow, m_ovf);
    chk("misalign", misalign, m_mis);
    if (!rst) begin
      if (out_valid && out_ready) npop++;
      am = '0; ad = '0;
      foreach (sq[k]) if (sq[k].start + 3 == cyc) begin am = sq[k].m; ad = sq[k].d; end
      pop  = mq.size() != 0 && out_ready;
      push = 0;
      if (am == 4'hF) begin
        if (mq.size() < 4 || pop) push = 1;
        else m_ovf = 1;
      end else if (am != 4'h0) m_mis = 1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ad);
    end
  endtask
  task automatic clear_model();
    sq.delete(); mq.delete(); m_ovf = 0; m_mis = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    clear_model();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {overflow, misalign}, 0);
    r_base = 1 << 30; r_off = 0;
    step(); step();
    rst = 0;
  endtask
  vec_t vt[5];
  int   s;
  initial begin
    vt[0] = '{6, -1, 0, 0, 0, 6};
    vt[1] = '{5, -1, 8, 1, 0, 4};
    vt[2] = '{5, -1, 7, 0, 0, 5};
    vt[3] = '{3,  1, 0, 0, 1, 2};
    vt[4] = '{3, -1, -1, 0, 0, 3};
    #2;
    do_reset();
    s = cyc + 2;
    add_row(s, 32'h13121110, 4'hF);
    while (cyc < s + 4) begin
      step();
      if (cyc < s + 4) chk("t1_early_valid", out_valid, 0);
    end
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h13121110);
    chk("t1_count", count, 1);
    foreach (vt[v]) begin
      do_reset();
      npop = 0;
      s = cyc + 2;
      for (int k = 0; k < vt[v].nrows; k++)
        add_row(s + k, $urandom, (k == vt[v].drop_row) ? 4'b1011 : 4'hF);
      r_base = s; r_off = vt[v].rdy_off;
      for (int n = 0; n < 36; n++) step();
      chk($sformatf("vec%0d_overflow", v), overflow, vt[v].exp_ovf);
      chk($sformatf("vec%0d_misalign", v), misalign, vt[v].exp_mis);
      chk($sformatf("vec%0d_rows_out", v), npop, vt[v].exp_out);
      chk($sformatf("vec%0d_drained", v), count, 0);
    end
    do_reset();
    s = cyc + 2;
    for (int k = 0; k < 3; k++) add_row(s + k, $urandom, 4'hF);
    while (cyc < s + 5) step();
    chk("t6_stored_before", count, 2);
    #2 rst = 1;
    #1;
    chk("t6_valid_now", out_valid, 0);
    chk("t6_count_now", count, 0);
    chk("t6_flags_now", {overflow, misalign}, 0);
    clear_model();
    step();
    rst = 0;
    npop = 0;
    r_base = 0; r_off = 0;
    for (int n = 0; n < 10; n++) step();
    chk("t6_no_rows", npop, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
